// File: rtl/phase_strobe_checker.sv
// Monitors the four one-hot phase strobes, decodes the active phase index and
// tracks 0->1->2->3->0 sequencing with lock acquisition and error counting.
module phase_strobe_checker #(
    parameter int LOCK_CNT  = 4,
    parameter int LOSS_CNT  = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           phase_in,
    input  logic                 err_clr,
    output logic [1:0]           phase_idx,
    output logic                 phase_valid,
    output logic                 locked,
    output logic                 seq_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int GOOD_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam int BAD_W  = (LOSS_CNT > 1) ? $clog2(LOSS_CNT) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [3:0]          phase_q;
    logic [1:0]          prev_idx, prev_next;
    logic [GOOD_W-1:0]   good_cnt, good_next;
    logic [BAD_W-1:0]    bad_cnt, bad_next;

    logic                oh;
    logic [1:0]          idx;
    logic [1:0]          exp_idx;
    logic                seq_ok;
    logic                err_event;
    logic [ERR_CNT_W-1:0] err_count_next;

    // Decode of the captured strobes.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        idx = 2'd0;
        case (phase_q)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        oh      = $onehot(phase_q);
        exp_idx = prev_idx + 2'd1;
        seq_ok  = oh && (idx == exp_idx);
    end

    // State register and sequencing counters.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state    <= IDLE;
            prev_idx <= 2'd0;
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else begin
            state    <= state_next;
            prev_idx <= prev_next;
            good_cnt <= good_next;
            bad_cnt  <= bad_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        prev_next  = prev_idx;
        good_next  = good_cnt;
        bad_next   = bad_cnt;
        case (state)
            IDLE: begin
                if (oh) begin
                    state_next = ACQUIRE;
                    prev_next  = idx;
                    good_next  = '0;
                end
            end
            ACQUIRE: begin
                if (seq_ok) begin
                    prev_next = idx;
                    if (good_cnt == GOOD_W'(LOCK_CNT - 1)) begin
                        state_next = LOCKED;
                        bad_next   = '0;
                    end else begin
                        good_next = good_cnt + GOOD_W'(1);
                    end
                end else if (oh) begin
                    prev_next = idx;
                    good_next = '0;
                end else begin
                    state_next = IDLE;
                    good_next  = '0;
                end
            end
            LOCKED: begin
                if (seq_ok) begin
                    prev_next = idx;
                    bad_next  = '0;
                end else begin
                    // A one-hot strobe resyncs the sequence; anything else freewheels.
                    prev_next = oh ? idx : exp_idx;
                    if (bad_cnt == BAD_W'(LOSS_CNT - 1)) begin
                        state_next = IDLE;
                        good_next  = '0;
                        bad_next   = '0;
                    end else begin
                        bad_next = bad_cnt + BAD_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: error detection and saturating counter update.
    always_comb begin
        err_event      = (state == LOCKED) && !seq_ok;
        err_count_next = err_count;
        if (err_clr) begin
            err_count_next = err_event ? ERR_CNT_W'(1) : '0;
        end else if (err_event && (err_count != {ERR_CNT_W{1'b1}})) begin
            err_count_next = err_count + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= 4'b0000;
            phase_idx   <= 2'd0;
            phase_valid <= 1'b0;
            locked      <= 1'b0;
            seq_err     <= 1'b0;
            err_count   <= '0;
        end else begin
            phase_q     <= phase_in;
            phase_idx   <= oh ? idx : 2'd0;
            phase_valid <= oh;
            locked      <= (state_next == LOCKED);
            seq_err     <= err_event;
            err_count   <= err_count_next;
        end
    end

endmodule

// File: tb/tb_phase_strobe_checker.sv
// Directed bench for phase_strobe_checker: default instance plus a narrow-counter,
// high-loss-tolerance instance sharing the same stimulus.
module tb_phase_strobe_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       err_clr = 1'b0;
    logic [3:0] phase_in = 4'b0000;

    logic [1:0] a_phase_idx;
    logic       a_phase_valid, a_locked, a_seq_err;
    logic [7:0] a_err_count;

    logic [1:0] b_phase_idx;
    logic       b_phase_valid, b_locked, b_seq_err;
    logic [1:0] b_err_count;

    int n_checks = 0;
    int n_errors = 0;

    phase_strobe_checker dut_a (
        .clk         (clk),
        .rst         (rst),
        .phase_in    (phase_in),
        .err_clr     (err_clr),
        .phase_idx   (a_phase_idx),
        .phase_valid (a_phase_valid),
        .locked      (a_locked),
        .seq_err     (a_seq_err),
        .err_count   (a_err_count)
    );

    phase_strobe_checker #(.LOCK_CNT(4), .LOSS_CNT(8), .ERR_CNT_W(2)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .phase_in    (phase_in),
        .err_clr     (err_clr),
        .phase_idx   (b_phase_idx),
        .phase_valid (b_phase_valid),
        .locked      (b_locked),
        .seq_err     (b_seq_err),
        .err_count   (b_err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] oh_of(input int i);
        logic [3:0] v;
        v = 4'b0001 << (i % 4);
        return v;
    endfunction

    // Apply inputs, take one rising edge, sample 1 time unit later.
    task automatic tick(input logic [3:0] p, input logic clr);
        phase_in = p;
        err_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_and_check(input string tag);
        rst = 1'b1;
        tick(4'b1000, 1'b1);
        rst = 1'b0;
        check({tag, "_idx"},   32'(a_phase_idx),   32'd0);
        check({tag, "_valid"}, 32'(a_phase_valid), 32'd0);
        check({tag, "_lock"},  32'(a_locked),      32'd0);
        check({tag, "_serr"},  32'(a_seq_err),     32'd0);
        check({tag, "_cnt"},   32'(a_err_count),   32'd0);
        check({tag, "_bcnt"},  32'(b_err_count),   32'd0);
    endtask

    // Ideal 0,1,2,3 stream; idx appears two edges later, lock after edge 6.
    task automatic ideal_run(input string tag, input int n);
        for (int k = 1; k <= n; k++) begin
            tick(oh_of(k - 1), 1'b0);
            check($sformatf("%s_valid_%0d", tag, k), 32'(a_phase_valid), 32'(k >= 2));
            if (k >= 2)
                check($sformatf("%s_idx_%0d", tag, k), 32'(a_phase_idx), 32'((k - 2) % 4));
            check($sformatf("%s_lock_%0d", tag, k), 32'(a_locked), 32'(k >= 6));
            check($sformatf("%s_serr_%0d", tag, k), 32'(a_seq_err), 32'd0);
            check($sformatf("%s_cnt_%0d", tag, k), 32'(a_err_count), 32'd0);
        end
    endtask

    initial begin
        int exp_b_cnt[5] = '{1, 2, 3, 3, 3};

        tick(4'b0000, 1'b0);
        reset_and_check("rst0");
        ideal_run("ideal", 12);

        // Single non-one-hot strobe in the phase-1 slot while locked.
        tick(4'b0001, 1'b0);
        check("inj_pre_lock", 32'(a_locked), 32'd1);
        tick(4'b0011, 1'b0);
        check("inj_pre_serr", 32'(a_seq_err), 32'd0);
        tick(4'b0100, 1'b0);
        check("inj_serr",  32'(a_seq_err),     32'd1);
        check("inj_cnt",   32'(a_err_count),   32'd1);
        check("inj_lock",  32'(a_locked),      32'd1);
        check("inj_valid", 32'(a_phase_valid), 32'd0);
        tick(4'b1000, 1'b0);
        check("fw_serr",  32'(a_seq_err),   32'd0);
        check("fw_idx",   32'(a_phase_idx), 32'd2);
        check("fw_cnt",   32'(a_err_count), 32'd1);
        tick(4'b0001, 1'b0);
        check("fw2_serr", 32'(a_seq_err),   32'd0);
        check("fw2_idx",  32'(a_phase_idx), 32'd3);
        check("fw2_lock", 32'(a_locked),    32'd1);

        // Clear the count, then two dead cycles drop lock.
        tick(4'b0000, 1'b1);
        check("clr_cnt",   32'(a_err_count), 32'd0);
        check("clr_serr",  32'(a_seq_err),   32'd0);
        tick(4'b0000, 1'b0);
        check("loss1_serr", 32'(a_seq_err),   32'd1);
        check("loss1_cnt",  32'(a_err_count), 32'd1);
        check("loss1_lock", 32'(a_locked),    32'd1);
        tick(4'b0010, 1'b0);
        check("loss2_serr", 32'(a_seq_err),   32'd1);
        check("loss2_cnt",  32'(a_err_count), 32'd2);
        check("loss2_lock", 32'(a_locked),    32'd0);
        tick(4'b0100, 1'b0);
        check("idle_serr", 32'(a_seq_err),   32'd0);
        check("idle_cnt",  32'(a_err_count), 32'd2);
        tick(4'b1000, 1'b0);
        check("relock_a", 32'(a_locked), 32'd0);
        tick(4'b0001, 1'b0);
        check("relock_b", 32'(a_locked), 32'd0);
        tick(4'b0010, 1'b0);
        check("relock_c", 32'(a_locked), 32'd0);
        tick(4'b0100, 1'b0);
        check("relock_d",   32'(a_locked),    32'd1);
        check("relock_cnt", 32'(a_err_count), 32'd2);

        // Reset while locked with a non-zero count, then relock on schedule.
        reset_and_check("rst_lk");
        ideal_run("rerun", 8);

        // Reverse order never locks and never counts.
        reset_and_check("rst_rev");
        for (int k = 1; k <= 12; k++) begin
            tick(oh_of(3 - ((k - 1) % 4)), 1'b0);
            check($sformatf("rev_valid_%0d", k), 32'(a_phase_valid), 32'(k >= 2));
            if (k >= 2)
                check($sformatf("rev_idx_%0d", k), 32'(a_phase_idx), 32'(3 - ((k - 2) % 4)));
            check($sformatf("rev_lock_%0d", k), 32'(a_locked),    32'd0);
            check($sformatf("rev_serr_%0d", k), 32'(a_seq_err),   32'd0);
            check($sformatf("rev_cnt_%0d", k),  32'(a_err_count), 32'd0);
        end

        // Narrow saturating counter with high loss tolerance.
        reset_and_check("rst_b");
        for (int k = 1; k <= 8; k++) tick(oh_of(k - 1), 1'b0);
        check("b_lock_on", 32'(b_locked), 32'd1);
        tick(4'b0000, 1'b0);
        check("b_ok_serr", 32'(b_seq_err),   32'd0);
        check("b_ok_cnt",  32'(b_err_count), 32'd0);
        for (int e = 0; e < 5; e++) begin
            tick(4'b0000, 1'b0);
            check($sformatf("b_sat_cnt_%0d", e),  32'(b_err_count), 32'(exp_b_cnt[e]));
            check($sformatf("b_sat_serr_%0d", e), 32'(b_seq_err),   32'd1);
            check($sformatf("b_sat_lock_%0d", e), 32'(b_locked),    32'd1);
        end
        tick(4'b0000, 1'b1);
        check("b_clr_err_cnt",  32'(b_err_count), 32'd1);
        check("b_clr_err_serr", 32'(b_seq_err),   32'd1);
        check("b_clr_err_lock", 32'(b_locked),    32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
